// File: rtl/staged_fork_pkg.sv
// Shared stage types and elaboration-time helpers for staged_handshake_fork.
package staged_fork_pkg;

  localparam int STAGE_W     = 2;
  localparam int MAX_CH      = 8;
  localparam int STAGE_ALL_W = MAX_CH * STAGE_W;

  typedef logic [STAGE_W-1:0] stage_t;

  // Bitmask of channels whose stage is strictly below the stage of channel i.
  function automatic logic [MAX_CH-1:0] lower_mask(input logic [STAGE_ALL_W-1:0] ch_stage,
                                                   input int num_ch, input int i);
    logic [MAX_CH-1:0] m;
    m = '0;
    for (int j = 0; j < MAX_CH; j++) begin
      if (j < num_ch && ch_stage[j*STAGE_W +: STAGE_W] < ch_stage[i*STAGE_W +: STAGE_W])
        m[j] = 1'b1;
    end
    return m;
  endfunction

  function automatic stage_t max_stage(input logic [STAGE_ALL_W-1:0] ch_stage, input int num_ch);
    stage_t s;
    s = '0;
    for (int j = 0; j < MAX_CH; j++) begin
      if (j < num_ch && ch_stage[j*STAGE_W +: STAGE_W] > s)
        s = ch_stage[j*STAGE_W +: STAGE_W];
    end
    return s;
  endfunction

endpackage

// File: rtl/fork_skid1.sv
// One-entry bypassing skid buffer: empty -> input passes straight through,
// a write that meets a stalled output is parked until the output accepts it.
module fork_skid1 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  full,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] buf_q;

  assign out_valid = full | in_valid;
  assign out_data  = full ? buf_q : in_data;
  assign overflow  = in_valid & full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      buf_q <= '0;
    end else if (full) begin
      if (out_ready) full <= 1'b0;
    end else if (in_valid && !out_ready) begin
      full  <= 1'b1;
      buf_q <= in_data;
    end
  end

endmodule

// File: rtl/staged_handshake_fork.sv
// Stage-ordered fork of one valid/ready input into NUM_CH channels.
// Define STAGED_FORK_SKID_EN to give every top-stage channel a one-entry skid buffer.
module staged_handshake_fork
  import staged_fork_pkg::*;
#(
  parameter int                        DATA_WIDTH = 32,
  parameter int                        NUM_CH     = 3,
  parameter logic [NUM_CH*STAGE_W-1:0] CH_STAGE   = {2'd2, 2'd1, 2'd0},
  parameter int                        CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH*CNT_WIDTH-1:0]  ch_cnt,
  output logic                         err
);

  localparam logic [STAGE_ALL_W-1:0] STAGES = STAGE_ALL_W'(CH_STAGE);

  // Handshake: a transfer happens on a cycle where valid & ready are both high;
  // valid/data never change before that transfer (upstream holds in_valid/in_data).
  logic [NUM_CH-1:0] done, f_valid, f_ready, ok, pre_ok, ch_fire;
  logic              in_fire;

  // ok[j] means "channel j has fired or fires now" once in_valid is high, written
  // from registers and inputs only so the stage chain has no combinational loop.
  assign ok       = done | (f_ready & {NUM_CH{in_valid}});
  assign in_ready = ~rst & (&(done | (f_ready & pre_ok)));
  assign in_fire  = in_valid & in_ready;
  assign ch_fire  = ch_valid & ch_ready;

`ifdef STAGED_FORK_SKID_EN
  localparam stage_t TOP_STAGE = max_stage(STAGES, NUM_CH);
  logic [NUM_CH-1:0] ovf;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [NUM_CH-1:0] LMASK = NUM_CH'(lower_mask(STAGES, NUM_CH, i));
    logic [CNT_WIDTH-1:0] cnt;

    assign pre_ok[i]  = &(ok | ~LMASK);
    assign f_valid[i] = in_valid & ~rst & ~done[i] & pre_ok[i];

`ifdef STAGED_FORK_SKID_EN
    if (STAGES[i*STAGE_W +: STAGE_W] == TOP_STAGE) begin : g_skid
      logic full;
      fork_skid1 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (f_valid[i] & ~full),
        .in_data   (in_data),
        .out_valid (ch_valid[i]),
        .out_ready (ch_ready[i]),
        .out_data  (ch_data[i*DATA_WIDTH +: DATA_WIDTH]),
        .full      (full),
        .overflow  (ovf[i])
      );
      assign f_ready[i] = ~full;
    end else begin : g_direct
      assign ch_valid[i]                         = f_valid[i];
      assign f_ready[i]                          = ch_ready[i];
      assign ch_data[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      assign ovf[i]                              = 1'b0;
    end
`else
    assign ch_valid[i]                         = f_valid[i];
    assign f_ready[i]                          = ch_ready[i];
    assign ch_data[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst)             cnt <= '0;
      else if (ch_fire[i]) cnt <= cnt + CNT_WIDTH'(1);
    end
    assign ch_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          done <= '0;
    else if (in_fire) done <= '0;
    else              done <= done | (f_valid & f_ready);
  end

`ifdef STAGED_FORK_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       err <= 1'b0;
    else if (|ovf) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_staged_handshake_fork.sv
// Directed bench for staged_handshake_fork: default 3-stage fork plus a 4-channel two-stage instance.
module tb_staged_handshake_fork;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, err;
  logic [31:0] in_data;
  logic [2:0]  ch_valid, ch_ready;
  logic [95:0] ch_data, ch_cnt;

  logic        in_valid4, in_ready4, err4;
  logic [7:0]  in_data4;
  logic [3:0]  ch_valid4, ch_ready4;
  logic [31:0] ch_data4, ch_cnt4;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  staged_handshake_fork dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data), .ch_cnt(ch_cnt), .err(err)
  );

  staged_handshake_fork #(
    .DATA_WIDTH(8), .NUM_CH(4), .CH_STAGE({2'd1, 2'd1, 2'd0, 2'd0}), .CNT_WIDTH(8)
  ) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .ch_valid(ch_valid4), .ch_ready(ch_ready4), .ch_data(ch_data4), .ch_cnt(ch_cnt4), .err(err4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] dat(input int i);
    return ch_data[i*32 +: 32];
  endfunction

  function automatic logic [31:0] cnt(input int i);
    return ch_cnt[i*32 +: 32];
  endfunction

  function automatic logic [7:0] cnt4(input int i);
    return ch_cnt4[i*8 +: 8];
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; ch_ready = 3'b111;
    in_valid4 = 1'b0; in_data4 = 8'h0; ch_ready4 = 4'b0;
    #2;
    check("rst_ch_valid", 64'(ch_valid), 64'(3'b000));
    check("rst_in_ready", 64'(in_ready), 64'(1'b0));
    check("rst_err", 64'(err), 64'(1'b0));
    for (int i = 0; i < 3; i++) check("rst_cnt", 64'(cnt(i)), 64'(0));
    tick();
    rst = 1'b0; in_valid = 1'b0;

    // 1: full-throughput streaming
    in_valid = 1'b1; ch_ready = 3'b111;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'(32'hA0 + k);
      exp_q.push_back(in_data);
      settle();
      check("t1_in_ready", 64'(in_ready), 64'(1'b1));
      check("t1_ch_valid", 64'(ch_valid), 64'(3'b111));
      check("t1_data2", 64'(dat(2)), 64'(32'(32'hA0 + k)));
      check("t1_data1", 64'(dat(1)), 64'(exp_q.pop_front()));
      tick();
    end
    in_valid = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) check("t1_cnt", 64'(cnt(i)), 64'(4));

    // 2: stage 0 stalls, later stages wait, then all fire together
    in_valid = 1'b1; in_data = 32'h11; ch_ready = 3'b110;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t2_stall_valid", 64'(ch_valid), 64'(3'b001));
      check("t2_stall_ready", 64'(in_ready), 64'(1'b0));
      tick();
    end
    ch_ready = 3'b111;
    settle();
    check("t2_go_valid", 64'(ch_valid), 64'(3'b111));
    check("t2_go_ready", 64'(in_ready), 64'(1'b1));
    tick();

    // 3: ch0 fires while ch1 stalls
    in_data = 32'h12; ch_ready = 3'b101;
    settle();
    check("t3_first_valid", 64'(ch_valid), 64'(3'b011));
    check("t3_first_ready", 64'(in_ready), 64'(1'b0));
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t3_hold_valid", 64'(ch_valid), 64'(3'b010));
      check("t3_hold_cnt0", 64'(cnt(0)), 64'(6));
      check("t3_hold_cnt1", 64'(cnt(1)), 64'(5));
      tick();
    end
    ch_ready = 3'b111;
    settle();
    check("t3_go_valid", 64'(ch_valid), 64'(3'b110));
    check("t3_go_ready", 64'(in_ready), 64'(1'b1));
    tick();
    in_valid = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) check("t3_cnt", 64'(cnt(i)), 64'(6));

    // 4: top stage not ready
    in_valid = 1'b1; in_data = 32'h22; ch_ready = 3'b011;
    settle();
    check("t4_first_valid", 64'(ch_valid), 64'(3'b111));
`ifdef STAGED_FORK_SKID_EN
    check("t4_skid_ready", 64'(in_ready), 64'(1'b1));
    tick();
    in_valid = 1'b0;
    settle();
    check("t4_skid_valid", 64'(ch_valid), 64'(3'b100));
    check("t4_skid_data", 64'(dat(2)), 64'(32'h22));
    check("t4_skid_err", 64'(err), 64'(1'b0));
    check("t4_skid_cnt2", 64'(cnt(2)), 64'(6));
    ch_ready = 3'b111;
    tick();
`else
    check("t4_first_ready", 64'(in_ready), 64'(1'b0));
    tick();
    settle();
    check("t4_hold_valid", 64'(ch_valid), 64'(3'b100));
    check("t4_hold_ready", 64'(in_ready), 64'(1'b0));
    check("t4_hold_cnt1", 64'(cnt(1)), 64'(7));
    check("t4_hold_cnt2", 64'(cnt(2)), 64'(6));
    ch_ready = 3'b111;
    settle();
    check("t4_go_ready", 64'(in_ready), 64'(1'b1));
    tick();
    in_valid = 1'b0;
`endif
    settle();
    for (int i = 0; i < 3; i++) check("t4_cnt", 64'(cnt(i)), 64'(7));

    // 5: asynchronous reset with ch0 already done
    in_valid = 1'b1; in_data = 32'h33; ch_ready = 3'b101;
    tick();
    settle();
    check("t5_pre_cnt0", 64'(cnt(0)), 64'(8));
    check("t5_pre_valid", 64'(ch_valid), 64'(3'b010));
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(ch_valid), 64'(3'b000));
    check("t5_rst_ready", 64'(in_ready), 64'(1'b0));
    for (int i = 0; i < 3; i++) check("t5_rst_cnt", 64'(cnt(i)), 64'(0));
    tick();
    rst = 1'b0; ch_ready = 3'b000;
    settle();
    check("t5_replay_valid", 64'(ch_valid), 64'(3'b001));
    check("t5_replay_data", 64'(dat(0)), 64'(32'h33));
    ch_ready = 3'b111;
    settle();
    check("t5_replay_ready", 64'(in_ready), 64'(1'b1));
    tick();
    in_valid = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) check("t5_cnt", 64'(cnt(i)), 64'(1));

    // 6: two channels per stage on the 4-channel instance
    in_valid4 = 1'b1; in_data4 = 8'h44; ch_ready4 = 4'b0001;
    settle();
    check("t6_a_valid", 64'(ch_valid4), 64'(4'b0011));
    check("t6_a_ready", 64'(in_ready4), 64'(1'b0));
    tick();
    ch_ready4 = 4'b0110;
    settle();
    check("t6_b_valid", 64'(ch_valid4), 64'(4'b1110));
    check("t6_b_ready", 64'(in_ready4), 64'(1'b0));
    tick();
    ch_ready4 = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t6_stall_valid", 64'(ch_valid4), 64'(4'b1000));
      check("t6_stall_ready", 64'(in_ready4), 64'(1'b0));
      tick();
    end
    ch_ready4 = 4'b1000;
    settle();
    check("t6_go_ready", 64'(in_ready4), 64'(1'b1));
    check("t6_go_data3", 64'(ch_data4[31:24]), 64'(8'h44));
    tick();
    in_valid4 = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) check("t6_cnt", 64'(cnt4(i)), 64'(1));
    check("t6_err", 64'(err4), 64'(1'b0));

    // 8-bit counters wrap: 1 + 255 fires returns to zero
    in_valid4 = 1'b1; ch_ready4 = 4'b1111;
    for (int k = 0; k < 255; k++) begin
      in_data4 = 8'(k);
      tick();
    end
    in_valid4 = 1'b0;
    settle();
    check("wrap_cnt0", 64'(cnt4(0)), 64'(0));
    check("wrap_cnt3", 64'(cnt4(3)), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
